// File: rtl/mult_arbiter_if.sv
// Requester/multiplier-side bundle of the shared-multiplier arbiter.
// The slave modport is the arbiter's own view of the bundle.
interface mult_arbiter_if #(parameter int NREQ = 4);
  logic [NREQ-1:0]    req;
  logic [NREQ*11-1:0] req_a;
  logic [NREQ*8-1:0]  req_b;
  logic [NREQ-1:0]    gnt;
  logic [10:0]        mul_n1;
  logic [7:0]         mul_n2;
  logic [18:0]        mul_result;
  logic [NREQ-1:0]    rsp_valid;
  logic [18:0]        rsp_data;
  logic               busy;

  modport master (output req, req_a, req_b, mul_result,
                  input  gnt, mul_n1, mul_n2, rsp_valid, rsp_data, busy);
  modport slave  (input  req, req_a, req_b, mul_result,
                  output gnt, mul_n1, mul_n2, rsp_valid, rsp_data, busy);
endinterface

// File: rtl/mult_arbiter.sv
// Round-robin sharing of one fixed-latency signed 11x8 multiplier between NREQ
// requesters, with a tag pipeline routing each product back to its issuer.

module mult_arbiter_lane #(parameter int MAX_OUT = 4) (
  input  logic clk,
  input  logic rst_n,
  input  logic req,
  input  logic inc,
  input  logic dec,
  output logic elig
);
  logic [3:0] cnt;

  // Grant and response in the same edge cancel, so cnt never leaves 0..MAX_OUT.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)           cnt <= '0;
    else if (inc && !dec) cnt <= cnt + 4'd1;
    else if (dec && !inc) cnt <= cnt - 4'd1;
  end

  assign elig = req && (cnt != 4'(MAX_OUT));
endmodule

module mult_arbiter #(
  parameter int NREQ    = 4,
  parameter int LAT     = 8,
  parameter int MAX_OUT = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  mult_arbiter_if.slave bus
);
  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int IW = PW + 1;

  logic [PW-1:0]       ptr;
  logic [NREQ-1:0]     elig, gnt, dec;
  logic                found;
  logic [PW-1:0]       win;
  logic [IW-1:0]       idx;
  logic [LAT:0]        vld_pipe;
  logic [LAT:0][2:0]   id_pipe;
  logic [10:0]         n1_q;
  logic [7:0]          n2_q;
  logic [NREQ-1:0]     rsp_valid_q;
  logic [18:0]         rsp_data_q;

  mult_arbiter_lane #(.MAX_OUT(MAX_OUT)) u_lane [NREQ-1:0] (
    .clk  (clk),
    .rst_n(rst_n),
    .req  (bus.req),
    .inc  (gnt),
    .dec  (dec),
    .elig (elig)
  );

  // First eligible requester at or after ptr, wrapping modulo NREQ.
  always_comb begin
    found = 1'b0;
    win   = '0;
    idx   = '0;
    for (int o = 0; o < NREQ; o++) begin
      idx = IW'(ptr) + IW'(o);
      if (idx >= IW'(NREQ)) idx = idx - IW'(NREQ);
      if (!found && elig[idx[PW-1:0]]) begin
        found = 1'b1;
        win   = idx[PW-1:0];
      end
    end
  end

  assign gnt = found ? (NREQ'(1) << win) : '0;

  for (genvar i = 0; i < NREQ; i++) begin : g_dec
    assign dec[i] = vld_pipe[LAT] && (id_pipe[LAT] == 3'(i));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr      <= '0;
      n1_q     <= '0;
      n2_q     <= '0;
      vld_pipe <= '0;
      id_pipe  <= '0;
    end else begin
      n1_q     <= found ? bus.req_a[11*win +: 11] : 11'd0;
      n2_q     <= found ? bus.req_b[8*win +: 8]   : 8'd0;
      vld_pipe <= {vld_pipe[LAT-1:0], found};
      id_pipe  <= {id_pipe[LAT-1:0], 3'(win)};
      if (found) ptr <= (int'(win) == NREQ-1) ? '0 : win + PW'(1);
    end
  end

  // Last tag stage lines up with mul_result; data holds between responses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid_q <= '0;
      rsp_data_q  <= '0;
    end else begin
      rsp_valid_q <= vld_pipe[LAT] ? (NREQ'(1) << id_pipe[LAT]) : '0;
      if (vld_pipe[LAT]) rsp_data_q <= bus.mul_result;
    end
  end

  assign bus.gnt       = gnt;
  assign bus.mul_n1    = n1_q;
  assign bus.mul_n2    = n2_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_data  = rsp_data_q;
  assign bus.busy      = (|vld_pipe) || (|rsp_valid_q);
endmodule
